// File: rtl/fetch_ctrl_if.sv
// Fetch-control handshake bundle: hazard/redirect/interrupt inputs and PC-steering outputs.
interface fetch_ctrl_if;
    logic        stall;
    logic        EXT_in;
    logic        interrupt_en;
    logic        irq_return;
    logic        pc_next_sel;
    logic        pcJalSrc_EXE;
    logic [1:0]  pc_src;
    logic        pc_en;
    logic        flush;
    logic        irq_ack;
    logic        in_handler;
    logic [15:0] redirect_cnt;

    modport master (
        output stall, EXT_in, interrupt_en, irq_return, pc_next_sel, pcJalSrc_EXE,
        input  pc_src, pc_en, flush, irq_ack, in_handler, redirect_cnt
    );

    modport slave (
        input  stall, EXT_in, interrupt_en, irq_return, pc_next_sel, pcJalSrc_EXE,
        output pc_src, pc_en, flush, irq_ack, in_handler, redirect_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC mux/enable, pipeline flush and interrupt entry/return sequencing.
// Optional FETCH_CTRL_IRQ_SYNC_EN adds a two-flop synchronizer on EXT_in.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    fetch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_IRQ_PEND, S_HANDLER} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_ext;
    logic        w_irq_req;
    logic        w_redirect;
    logic        w_entry;
    logic [15:0] r_redirect_cnt;

`ifdef FETCH_CTRL_IRQ_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.EXT_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ext = r_sync2;
`else
    assign w_ext = bus.EXT_in;
`endif

    assign w_redirect = bus.pc_next_sel && (r_state != S_BOOT);
    assign w_irq_req  = w_ext && bus.interrupt_en && (r_state != S_HANDLER);
    // A latched pending request enters regardless of the current EXT_in level.
    assign w_entry    = !w_redirect && !bus.stall &&
                        (((r_state == S_RUN) && w_irq_req) || (r_state == S_IRQ_PEND));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_BOOT;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_BOOT:     w_next = S_RUN;
            S_RUN: begin
                if (w_entry)                      w_next = S_HANDLER;
                else if (!w_redirect && w_irq_req) w_next = S_IRQ_PEND;
            end
            S_IRQ_PEND: if (w_entry)        w_next = S_HANDLER;
            S_HANDLER:  if (bus.irq_return) w_next = S_RUN;
            default:    w_next = S_BOOT;
        endcase
    end

    always_comb begin
        bus.pc_src     = 2'b00;
        bus.pc_en      = !bus.stall;
        bus.flush      = 1'b0;
        bus.irq_ack    = 1'b0;
        bus.in_handler = (r_state == S_HANDLER);
        if (r_state == S_BOOT) begin
            bus.pc_en = 1'b0;
            bus.flush = 1'b1;
        end else if (w_redirect) begin
            bus.pc_src = bus.pcJalSrc_EXE ? 2'b10 : 2'b01;
            bus.pc_en  = 1'b1;
            bus.flush  = 1'b1;
        end else if (w_entry) begin
            bus.pc_src  = 2'b11;
            bus.pc_en   = 1'b1;
            bus.flush   = 1'b1;
            bus.irq_ack = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_redirect_cnt <= 16'd0;
        else if (w_redirect && (r_redirect_cnt != 16'hFFFF))
            r_redirect_cnt <= r_redirect_cnt + 16'd1;
    end

    assign bus.redirect_cnt = r_redirect_cnt;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver queues hand-computed outputs, negedge monitor checks them.
module tb_fetch_ctrl;
    typedef struct packed {
        logic [1:0]  src;
        logic        pen;
        logic        fl;
        logic        ack;
        logic        ih;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   id_q[$];
    int   n_run;
    int   n_fail;
    int   vec_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drv(input logic r, input logic st, input logic ext, input logic ien,
                       input logic iret, input logic pns, input logic jal,
                       input logic [1:0] esrc, input logic epen, input logic efl,
                       input logic eack, input logic eih, input logic [15:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.stall        = st;
        bus.EXT_in       = ext;
        bus.interrupt_en = ien;
        bus.irq_return   = iret;
        bus.pc_next_sel  = pns;
        bus.pcJalSrc_EXE = jal;
        e.src = esrc; e.pen = epen; e.fl = efl; e.ack = eack; e.ih = eih; e.cnt = ecnt;
        exp_q.push_back(e);
        id_q.push_back(vec_id);
        vec_id++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t g;
            int   id;
            e = exp_q.pop_front();
            id = id_q.pop_front();
            g.src = bus.pc_src; g.pen = bus.pc_en; g.fl = bus.flush;
            g.ack = bus.irq_ack; g.ih = bus.in_handler; g.cnt = bus.redirect_cnt;
            n_run++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL vec%0d: got src=%b pen=%b fl=%b ack=%b ih=%b cnt=%h, want src=%b pen=%b fl=%b ack=%b ih=%b cnt=%h",
                         id, g.src, g.pen, g.fl, g.ack, g.ih, g.cnt,
                         e.src, e.pen, e.fl, e.ack, e.ih, e.cnt);
            end
        end
    end

    initial begin
        n_run = 0; n_fail = 0; vec_id = 0;
        rst = 1'b0;
        bus.stall = 0; bus.EXT_in = 0; bus.interrupt_en = 0;
        bus.irq_return = 0; bus.pc_next_sel = 0; bus.pcJalSrc_EXE = 0;

        //  rst st ext ien iret pns jal | src  pen fl ack ih cnt
        drv(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 1, 0, 0, 16'd0);   // in reset
        drv(1, 0, 0, 0, 0, 0, 0,  2'b00, 0, 1, 0, 0, 16'd0);   // single BOOT cycle
        drv(1, 0, 0, 0, 0, 0, 0,  2'b00, 1, 0, 0, 0, 16'd0);   // RUN
        drv(1, 0, 0, 0, 0, 0, 0,  2'b00, 1, 0, 0, 0, 16'd0);
        drv(1, 1, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0, 0, 16'd0);   // plain stall
        drv(1, 1, 0, 0, 0, 1, 1,  2'b10, 1, 1, 0, 0, 16'd0);   // JALR redirect beats stall
        drv(1, 0, 0, 0, 0, 1, 0,  2'b01, 1, 1, 0, 0, 16'd1);   // branch redirect
        drv(1, 0, 0, 0, 0, 0, 0,  2'b00, 1, 0, 0, 0, 16'd2);
        drv(1, 1, 1, 1, 0, 0, 0,  2'b00, 0, 0, 0, 0, 16'd2);   // irq while stalled -> PEND
        drv(1, 1, 1, 1, 0, 0, 0,  2'b00, 0, 0, 0, 0, 16'd2);
        drv(1, 1, 1, 1, 0, 0, 0,  2'b00, 0, 0, 0, 0, 16'd2);
        drv(1, 0, 0, 1, 0, 0, 0,  2'b11, 1, 1, 1, 0, 16'd2);   // entry though EXT_in dropped
        drv(1, 0, 1, 1, 0, 0, 0,  2'b00, 1, 0, 0, 1, 16'd2);   // HANDLER masks irq
        drv(1, 1, 1, 1, 0, 0, 0,  2'b00, 0, 0, 0, 1, 16'd2);
        drv(1, 0, 1, 1, 1, 1, 0,  2'b01, 1, 1, 0, 1, 16'd2);   // return with redirect
        drv(1, 0, 1, 1, 0, 0, 0,  2'b11, 1, 1, 1, 0, 16'd3);   // re-entry after return
        drv(1, 0, 1, 1, 0, 0, 0,  2'b00, 1, 0, 0, 1, 16'd3);   // no back-to-back ack
        drv(1, 0, 0, 0, 1, 1, 1,  2'b10, 1, 1, 0, 1, 16'd3);
        drv(1, 0, 1, 0, 0, 0, 0,  2'b00, 1, 0, 0, 0, 16'd4);   // interrupts disabled
        drv(1, 1, 1, 1, 0, 0, 0,  2'b00, 0, 0, 0, 0, 16'd4);   // -> PEND
        drv(1, 0, 1, 1, 0, 1, 0,  2'b01, 1, 1, 0, 0, 16'd4);   // PEND serves redirect first
        drv(1, 0, 1, 1, 0, 0, 0,  2'b11, 1, 1, 1, 0, 16'd5);   // then entry
        drv(1, 0, 0, 0, 1, 0, 0,  2'b00, 1, 0, 0, 1, 16'd5);   // return, no redirect
        drv(1, 0, 0, 0, 0, 0, 0,  2'b00, 1, 0, 0, 0, 16'd5);
        drv(1, 0, 1, 1, 0, 1, 0,  2'b01, 1, 1, 0, 0, 16'd5);   // redirect beats entry in RUN
        drv(1, 0, 0, 0, 0, 0, 0,  2'b00, 1, 0, 0, 0, 16'd6);

        for (int i = 0; i < 65532; i++) begin
            int c;
            c = (6 + i > 65535) ? 65535 : 6 + i;
            drv(1, 0, 0, 0, 0, 1, 0, 2'b01, 1, 1, 0, 0, c[15:0]);
        end
        drv(1, 0, 0, 0, 0, 0, 0,  2'b00, 1, 0, 0, 0, 16'hFFFF); // saturated
        drv(1, 0, 1, 1, 0, 0, 0,  2'b11, 1, 1, 1, 0, 16'hFFFF);
        drv(1, 0, 0, 0, 0, 0, 0,  2'b00, 1, 0, 0, 1, 16'hFFFF);
        drv(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 1, 0, 0, 16'd0);   // async reset mid-HANDLER
        drv(1, 0, 1, 1, 0, 0, 0,  2'b00, 0, 1, 0, 0, 16'd0);   // BOOT ignores irq
        drv(1, 1, 1, 1, 0, 0, 0,  2'b00, 0, 0, 0, 0, 16'd0);   // RUN stalled -> PEND
        drv(0, 0, 0, 0, 0, 0, 0,  2'b00, 0, 1, 0, 0, 16'd0);   // reset mid-PEND
        drv(1, 0, 0, 0, 0, 0, 0,  2'b00, 0, 1, 0, 0, 16'd0);
        drv(1, 0, 0, 0, 0, 0, 0,  2'b00, 1, 0, 0, 0, 16'd0);   // pending discarded

        repeat (3) @(posedge clk);
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 stall  in  1  hazard stall from decode; freezes PC when no redirect.
REQ-004 EXT_in  in  1  external interrupt request, level, asynchronous to clk.
REQ-005 interrupt_en  in  1  global interrupt enable.
REQ-006 irq_return  in  1  return-from-handler decoded in EXE, one-cycle pulse.
REQ-007 pc_next_sel  in  1  branch/jump taken in EXE (redirect request).
REQ-008 pcJalSrc_EXE  in  1  redirect target is ALU result (JALR) rather than branch_jump_addr.
REQ-009 pc_src  out  2  PC mux select: 00 pc+4, 01 branch_jump_addr, 10 alu_result_EXE, 11 interrupt_handling_addr.
REQ-010 pc_en  out  1  PC register write enable.
REQ-011 flush  out  1  clears IF/ID and ID/EX pipeline registers.
REQ-012 irq_ack  out  1  one-cycle pulse on interrupt entry.
REQ-013 in_handler  out  1  high while in HANDLER state.
REQ-014 redirect_cnt  out  16  saturating count of EXE redirects.

Function
REQ-015 States BOOT, RUN, IRQ_PEND, HANDLER; all outputs registered-state-derived combinationally except redirect_cnt (registered).
REQ-016 irq_req = synced EXT_in AND interrupt_en AND state != HANDLER.
REQ-017 BOOT: pc_en=0, pc_src=00, flush=1; unconditional move to RUN next cycle.
REQ-018 Redirect (pc_next_sel=1) in any non-BOOT state: pc_src=10 if pcJalSrc_EXE else 01, pc_en=1, flush=1, overriding stall; state unchanged except as REQ-022.
REQ-019 RUN, no redirect, irq_req, stall=0: pc_src=11, pc_en=1, flush=1, irq_ack=1, go HANDLER.
REQ-020 RUN, no redirect, irq_req, stall=1: pc_en=0, go IRQ_PEND (request latched; later deassertion of EXT_in does not cancel).
REQ-021 IRQ_PEND: redirect served first (stay IRQ_PEND); first cycle with stall=0 and no redirect performs entry as REQ-019.
REQ-022 HANDLER: normal fetch/redirect; irq masked; irq_return=1 -> RUN next cycle (return redirect carried by pc_next_sel same cycle).
REQ-023 No redirect, no entry: pc_src=00, pc_en=!stall, flush=0.
REQ-024 irq_ack never asserts in consecutive cycles; at most one per HANDLER visit.
REQ-025 redirect_cnt increments once per cycle with pc_next_sel=1 (not BOOT), saturates at 0xFFFF, no wrap.
REQ-026 EXT_in still high when returning to RUN re-enters HANDLER no earlier than the cycle after leaving it.

Reset
REQ-027 rst low asynchronously forces state BOOT, redirect_cnt=0, synchronizer flops=0, irq_ack=0, in_handler=0, pc_en=0, flush=1, pc_src=00.
REQ-028 Reset asserted mid-IRQ_PEND or HANDLER discards pending interrupt; first post-reset cycle is BOOT.

Configuration
REQ-029 Macro FETCH_CTRL_IRQ_SYNC_EN defined: EXT_in passes through two-flop synchronizer, entry latency 2 cycles longer.
REQ-030 Macro undefined: EXT_in used directly (already synchronous), RUN with EXT_in=1, interrupt_en=1, stall=0 enters in the same cycle.

Verification
REQ-031 Release rst, all inputs 0 -> one BOOT cycle (pc_en=0, flush=1), then pc_src=00, pc_en=1 each cycle.
REQ-032 RUN, pc_next_sel=1, pcJalSrc_EXE=1, stall=1 -> pc_src=10, pc_en=1, flush=1, redirect_cnt +1.
REQ-033 RUN, EXT_in=1, interrupt_en=1, stall=1 for 3 cycles then 0 (macro undefined) -> pc_en=0 three cycles, then pc_src=11, irq_ack=1, in_handler=1 next cycle.
REQ-034 HANDLER, EXT_in=1 held -> no second irq_ack; irq_return=1 with pc_next_sel=1 -> pc_src=01, then RUN, re-entry irq_ack next cycle.
REQ-035 IRQ_PEND, pc_next_sel=1 and stall=0 same cycle -> redirect served (pc_src=01), irq entry following cycle.
REQ-036 Force 65536 redirects -> redirect_cnt holds 0xFFFF; assert rst mid-HANDLER -> state BOOT, redirect_cnt=0, in_handler=0 immediately.
